// File: rtl/tcam_route_pkg.sv
// Shared types for the TCAM routing engine: command modes, FSM states,
// and the default-geometry entry record.
package tcam_route_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'b000,
    MODE_WRITE = 3'b001,
    MODE_READ  = 3'b010,
    MODE_FLUSH = 3'b011,
    MODE_CMP   = 3'b100,
    MODE_INV   = 3'b101
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MATCH,
    S_EMIT,
    S_RESP
  } state_t;

  localparam int unsigned DEF_KEY_W    = 8;
  localparam int unsigned DEF_DST_W    = 4;
  localparam int unsigned DEF_WEIGHT_W = 4;

  typedef struct packed {
    logic [DEF_KEY_W-1:0]    key;
    logic [DEF_KEY_W-1:0]    care;
    logic [DEF_DST_W-1:0]    dst;
    logic [DEF_WEIGHT_W-1:0] weight;
  } tcam_entry_t;

endpackage

// File: rtl/tcam_prio_enc.sv
// Find-first-set over a hit vector.
//   vec    : candidate bits
//   idx    : index of the lowest set bit (0 when none)
//   any    : at least one bit set
//   onehot : one-hot mask of the lowest set bit
module tcam_prio_enc
  import tcam_route_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic [N-1:0]     onehot
);

  always_comb begin
    idx = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (vec[i-1]) idx = IDX_W'(i - 1);
    end
  end

  assign any    = |vec;
  assign onehot = vec & (~vec + N'(1));

endmodule

// File: rtl/tcam_route_engine.sv
// Multi-bank ternary CAM mapping spike packet IDs to destination/weight.
//   cmd_*     : command channel (write/read/flush/compare/invalidate)
//   rsp_*     : response channel, all hits enumerated in ascending address
//   hit_count : number of matches of the most recent compare
module tcam_route_engine
  import tcam_route_pkg::*;
#(
  parameter  int unsigned KEY_W          = 8,
  parameter  int unsigned DST_W          = 4,
  parameter  int unsigned WEIGHT_W       = 4,
  parameter  int unsigned NUM_BANKS      = 2,
  parameter  int unsigned WORDS_PER_BANK = 16,
  localparam int unsigned NUM_ENTRIES    = NUM_BANKS * WORDS_PER_BANK,
  localparam int unsigned ADDR_W         = $clog2(NUM_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_mode,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [KEY_W-1:0]     cmd_key,
  input  logic [KEY_W-1:0]     cmd_care,
  input  logic [DST_W-1:0]     cmd_dst,
  input  logic [WEIGHT_W-1:0]  cmd_weight,
  input  logic [NUM_BANKS-1:0] cmd_bank_en,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic                 rsp_last,
  output logic [ADDR_W-1:0]    rsp_addr,
  output logic [KEY_W-1:0]     rsp_key,
  output logic [KEY_W-1:0]     rsp_care,
  output logic [DST_W-1:0]     rsp_dst,
  output logic [WEIGHT_W-1:0]  rsp_weight,
  output logic [ADDR_W:0]      hit_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef struct packed {
    logic [KEY_W-1:0]    key;
    logic [KEY_W-1:0]    care;
    logic [DST_W-1:0]    dst;
    logic [WEIGHT_W-1:0] weight;
  } entry_t;

  entry_t                 entries [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid;
  logic [NUM_ENTRIES-1:0] match;
  logic [NUM_ENTRIES-1:0] hit_vec;
  logic [NUM_ENTRIES-1:0] enc_onehot;
  logic [ADDR_W-1:0]      enc_idx;
  logic                   enc_any;
  logic                   emit_last;
  logic [CNT_W-1:0]       match_count;

  logic [KEY_W-1:0]       q_key;
  logic [KEY_W-1:0]       q_care;
  logic [NUM_BANKS-1:0]   q_bank_en;
  logic [ADDR_W-1:0]      rd_addr;

  state_t state, state_nxt;
  mode_t  mode;
  logic   accept;

  assign mode      = mode_t'(cmd_mode);
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = valid[i] && q_bank_en[i / WORDS_PER_BANK] &&
                 (((entries[i].key ^ q_key) & entries[i].care & q_care) == '0);
    end
  end

  always_comb begin
    match_count = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      match_count = match_count + CNT_W'(match[i]);
    end
  end

  tcam_prio_enc #(
    .N     (NUM_ENTRIES),
    .IDX_W (ADDR_W)
  ) u_prio_enc (
    .vec    (hit_vec),
    .idx    (enc_idx),
    .any    (enc_any),
    .onehot (enc_onehot)
  );

  // Last when nothing remains after the current bit; also true with no hits.
  assign emit_last = (hit_vec & ~enc_onehot) == '0;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (mode)
            MODE_READ: state_nxt = S_RESP;
            MODE_CMP:  state_nxt = S_MATCH;
            default:   state_nxt = S_IDLE;
          endcase
        end
      end
      S_MATCH: state_nxt = S_EMIT;
      S_EMIT:  if (rsp_ready && emit_last) state_nxt = S_IDLE;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      hit_vec   <= '0;
      hit_count <= '0;
      q_key     <= '0;
      q_care    <= '0;
      q_bank_en <= '0;
      rd_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (mode)
              MODE_WRITE: valid[cmd_addr] <= 1'b1;
              MODE_INV:   valid[cmd_addr] <= 1'b0;
              MODE_FLUSH: valid <= '0;
              MODE_READ:  rd_addr <= cmd_addr;
              MODE_CMP: begin
                q_key     <= cmd_key;
                q_care    <= cmd_care;
                q_bank_en <= cmd_bank_en;
              end
              default: ;
            endcase
          end
        end
        S_MATCH: begin
          hit_vec   <= match;
          hit_count <= match_count;
        end
        S_EMIT: begin
          if (rsp_ready) hit_vec <= hit_vec & ~enc_onehot;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && mode == MODE_WRITE) begin
      entries[cmd_addr] <= '{key: cmd_key, care: cmd_care, dst: cmd_dst, weight: cmd_weight};
    end
  end

  always_comb begin
    rsp_valid  = 1'b0;
    rsp_hit    = 1'b0;
    rsp_last   = 1'b0;
    rsp_addr   = '0;
    rsp_key    = '0;
    rsp_care   = '0;
    rsp_dst    = '0;
    rsp_weight = '0;
    if (!rst) begin
      case (state)
        S_RESP: begin
          rsp_valid  = 1'b1;
          rsp_hit    = valid[rd_addr];
          rsp_last   = 1'b1;
          rsp_addr   = rd_addr;
          rsp_key    = entries[rd_addr].key;
          rsp_care   = entries[rd_addr].care;
          rsp_dst    = entries[rd_addr].dst;
          rsp_weight = entries[rd_addr].weight;
        end
        S_EMIT: begin
          rsp_valid = 1'b1;
          rsp_hit   = enc_any;
          rsp_last  = emit_last;
          if (enc_any) begin
            rsp_addr   = enc_idx;
            rsp_dst    = entries[enc_idx].dst;
            rsp_weight = entries[enc_idx].weight;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
